// File: rtl/data_sync_tx.sv
// data_sync_tx: source-domain half of an enable-synchronized bus crossing.
// Holds a word on Async_bus, raises bus_EN, and completes a 4-phase
// handshake against the synchronized acknowledge from the destination.
module data_sync_tx #(
   parameter int unsigned NUM_Stages = 2,
   parameter int unsigned Width      = 8
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic [Width-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [Width-1:0] Async_bus,
   output logic             bus_EN,
   input  logic             bus_ACK,
   output logic             busy,
   output logic             done_pulse
);

   typedef enum logic [1:0] {IDLE, LOAD, REQ, DROP} state_t;

   state_t                state;
   state_t                state_nxt;
   logic [NUM_Stages-1:0] ack_sync;
   logic                  ack_s;
   logic [Width-1:0]      pend_data;
   logic                  pend_full;
   logic                  accept;
   logic                  load;
   logic                  en_nxt;
   logic                  done_nxt;

   assign ack_s    = ack_sync[NUM_Stages-1];
   assign in_ready = ~pend_full | (state == IDLE);
   assign accept   = in_valid & in_ready;
   assign load     = (state == IDLE) & pend_full;
   assign busy     = (state != IDLE);

   // Bring the asynchronous acknowledge into the CLK domain
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset)
         ack_sync <= '0;
      else
         ack_sync <= {ack_sync[NUM_Stages-2:0], bus_ACK};
   end

   // One-entry pending buffer; drain and refill may happen on the same edge
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         pend_data <= '0;
         pend_full <= 1'b0;
      end else begin
         if (accept)
            pend_data <= in_data;
         pend_full <= accept | (pend_full & ~load);
      end
   end

   // Handshake state register
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state and next registered outputs of the handshake
   always_comb begin
      state_nxt = state;
      en_nxt    = 1'b0;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (pend_full)
               state_nxt = LOAD;
         end
         LOAD: begin
            en_nxt    = 1'b1;
            state_nxt = REQ;
         end
         REQ: begin
            if (ack_s)
               state_nxt = DROP;
            else
               en_nxt = 1'b1;
         end
         DROP: begin
            if (!ack_s) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Registered outputs toward the destination: bus_EN straight from a flop,
   // Async_bus only updated on the IDLE->LOAD edge
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         Async_bus  <= '0;
         bus_EN     <= 1'b0;
         done_pulse <= 1'b0;
      end else begin
         if (load)
            Async_bus <= pend_data;
         bus_EN     <= en_nxt;
         done_pulse <= done_nxt;
      end
   end

endmodule

// File: tb/tb_data_sync_tx.sv
// Self-checking bench for data_sync_tx: per-cycle comparison against a
// transaction-level model, plus directed literal checks and a loopback
// through a behavioural destination synchronizer on an unrelated clock.
module tb_data_sync_tx;

   localparam int NS = 2;

   logic       CLK = 1'b0;
   logic       DCLK = 1'b0;
   logic       Reset = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_ready;
   logic [7:0] Async_bus;
   logic       bus_EN;
   logic       bus_ACK;
   logic       busy;
   logic       done_pulse;

   int n_checks = 0;
   int n_fail   = 0;

   // 0: bus_ACK = bus_EN delayed 3 CLK, 1: stuck low, 2: destination loopback
   int         ack_mode = 0;
   logic [2:0] dly = 3'b000;
   logic [1:0] d_sync = 2'b00;
   logic       d_prev = 1'b0;
   logic [7:0] rx[$];
   int         rx_pulses = 0;

   data_sync_tx #(.NUM_Stages(NS), .Width(8)) dut (
      .CLK        (CLK),
      .Reset      (Reset),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .Async_bus  (Async_bus),
      .bus_EN     (bus_EN),
      .bus_ACK    (bus_ACK),
      .busy       (busy),
      .done_pulse (done_pulse)
   );

   // CLK period 12, DCLK period 28 (3:7); DCLK edges are odd times, never on a CLK edge
   always #6 CLK = ~CLK;
   initial begin
      #1;
      forever #14 DCLK = ~DCLK;
   end

   assign bus_ACK = (ack_mode == 0) ? dly[2] : (ack_mode == 1) ? 1'b0 : d_sync[1];

   always @(negedge CLK) dly <= {dly[1:0], bus_EN};

   // Destination: two-flop sync of bus_EN, capture on its rising edge, echo as ack
   always @(posedge DCLK or negedge Reset) begin
      if (!Reset) begin
         d_sync <= 2'b00;
         d_prev <= 1'b0;
      end else begin
         d_sync <= {d_sync[0], bus_EN};
         d_prev <= d_sync[1];
         if (d_sync[1] && !d_prev) begin
            rx.push_back(Async_bus);
            rx_pulses <= rx_pulses + 1;
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level model ----------------
   // A transfer owns the bus from its load edge; the request is raised one
   // edge later, may see the ack from two edges after the load, and finishes
   // on the first edge afterwards where the ack is seen low again.
   logic [7:0] m_bus = 8'h00;
   logic [7:0] m_pend = 8'h00;
   logic       m_pfull = 1'b0;
   logic       m_active = 1'b0;
   logic       m_acked = 1'b0;
   int         m_age = 0;
   logic       m_en = 1'b0;
   logic       m_busy = 1'b0;
   logic       m_done = 1'b0;
   logic       m_ready = 1'b1;
   logic       hist[$];
   logic       m_acks;
   logic       m_acc;

   always @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         m_bus = 8'h00; m_pend = 8'h00; m_pfull = 1'b0; m_active = 1'b0;
         m_acked = 1'b0; m_age = 0; m_en = 1'b0; m_busy = 1'b0;
         m_done = 1'b0; m_ready = 1'b1;
         hist.delete();
         repeat (NS) hist.push_back(1'b0);
      end else begin
         // the FSM sees bus_ACK as sampled NS edges ago
         m_acks = hist.pop_front();
         hist.push_back(bus_ACK);
         m_acc  = in_valid && m_ready;
         m_done = 1'b0;
         if (m_active) begin
            m_age++;
            if (m_age >= 2 && !m_acked && m_acks)
               m_acked = 1'b1;
            else if (m_acked && !m_acks) begin
               m_active = 1'b0;
               m_done   = 1'b1;
            end
         end else if (m_pfull) begin
            m_bus    = m_pend;
            m_pfull  = 1'b0;
            m_active = 1'b1;
            m_acked  = 1'b0;
            m_age    = 0;
         end
         if (m_acc) begin
            m_pend  = in_data;
            m_pfull = 1'b1;
         end
         m_en    = m_active && (m_age >= 1) && !m_acked;
         m_busy  = m_active;
         m_ready = !m_pfull || !m_active;
      end
   end

   // ---------------- per-cycle compare ----------------
   logic [7:0] prev_bus = 8'h00;
   logic [7:0] bus_log[$];
   int         done_cnt = 0;

   always @(negedge CLK) begin
      check("Async_bus", Async_bus, m_bus);
      check("bus_EN", bus_EN, m_en);
      check("busy", busy, m_busy);
      check("done_pulse", done_pulse, m_done);
      check("in_ready", in_ready, m_ready);
      if (Reset && Async_bus != prev_bus) begin
         bus_log.push_back(Async_bus);
         check("en_at_bus_change", bus_EN, 0);
      end
      if (done_pulse) done_cnt++;
      prev_bus = Async_bus;
   end

   // ---------------- stimulus helpers ----------------
   task automatic push(input logic [7:0] d);
      in_valid = 1'b1;
      in_data  = d;
      for (int i = 0; i < 400 && !in_ready; i++) @(negedge CLK);
      if (!in_ready) check("push_timeout", in_ready, 1);
      @(negedge CLK);
      in_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int i;
      for (i = 0; i < budget; i++) begin
         @(negedge CLK);
         if (!busy && !m_pfull) break;
      end
      if (i >= budget) check("idle_timeout", busy, 0);
      repeat (2) @(negedge CLK);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int         d0;
   int         lb;
   int         rb;
   int         rp;
   logic [7:0] w;
   logic [7:0] sent[$];

   initial begin
      // reset state
      repeat (3) @(negedge CLK);
      check("rst_Async_bus", Async_bus, 0);
      check("rst_bus_EN", bus_EN, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done_pulse, 0);
      #2 Reset = 1'b1;
      @(negedge CLK);
      check("rst_ready", in_ready, 1);

      // single word
      d0 = done_cnt;
      push(8'hA5);
      check("t1_bus_e0", Async_bus, 0);
      check("t1_en_e0", bus_EN, 0);
      @(negedge CLK);
      check("t1_bus_e1", Async_bus, 8'hA5);
      check("t1_en_e1", bus_EN, 0);
      @(negedge CLK);
      check("t1_en_e2", bus_EN, 1);
      wait_idle(200);
      check("t1_done_cnt", done_cnt - d0, 1);
      check("t1_busy_after", busy, 0);

      // back-to-back
      d0 = done_cnt;
      lb = bus_log.size();
      push(8'h11);
      push(8'h22);
      check("b2b_ready_full", in_ready, 0);
      check("b2b_busy", busy, 1);
      check("b2b_bus_first", Async_bus, 8'h11);
      push(8'h33);
      wait_idle(400);
      check("b2b_done_cnt", done_cnt - d0, 3);
      check("b2b_log_len", bus_log.size() - lb, 3);
      if (bus_log.size() - lb == 3) begin
         check("b2b_log0", bus_log[lb], 8'h11);
         check("b2b_log1", bus_log[lb+1], 8'h22);
         check("b2b_log2", bus_log[lb+2], 8'h33);
      end

      // stuck ack
      ack_mode = 1;
      lb = bus_log.size();
      push(8'h5A);
      push(8'h6B);
      in_valid = 1'b1;
      in_data  = 8'h7C;
      repeat (10) @(negedge CLK);
      check("stuck_ready", in_ready, 0);
      check("stuck_en", bus_EN, 1);
      check("stuck_busy", busy, 1);
      in_valid = 1'b0;
      ack_mode = 0;
      wait_idle(400);
      check("stuck_log_len", bus_log.size() - lb, 2);
      if (bus_log.size() - lb == 2) begin
         check("stuck_log0", bus_log[lb], 8'h5A);
         check("stuck_log1", bus_log[lb+1], 8'h6B);
      end

      // data stability with in_data toggling while not accepted
      lb = bus_log.size();
      push(8'hC3);
      repeat (30) begin @(negedge CLK); in_data = 8'($urandom); end
      push(8'h3C);
      repeat (30) begin @(negedge CLK); in_data = 8'($urandom); end
      wait_idle(400);
      check("stab_log_len", bus_log.size() - lb, 2);
      if (bus_log.size() - lb == 2) begin
         check("stab_log0", bus_log[lb], 8'hC3);
         check("stab_log1", bus_log[lb+1], 8'h3C);
      end

      // reset during REQ
      push(8'h4D);
      for (int i = 0; i < 50 && !bus_EN; i++) @(negedge CLK);
      check("rst_req_en_seen", bus_EN, 1);
      #2 Reset = 1'b0;
      #1;
      check("rst_req_en", bus_EN, 0);
      check("rst_req_bus", Async_bus, 0);
      check("rst_req_busy", busy, 0);
      @(negedge CLK);
      #2 Reset = 1'b1;
      @(negedge CLK);
      check("rst_req_ready", in_ready, 1);
      lb = bus_log.size();
      push(8'h96);
      wait_idle(400);
      check("rst_req_next_len", bus_log.size() - lb, 1);
      if (bus_log.size() - lb == 1) check("rst_req_next", bus_log[lb], 8'h96);

      // destination loopback
      repeat (6) @(negedge CLK);
      ack_mode = 2;
      rb = rx.size();
      rp = rx_pulses;
      for (int k = 0; k < 50; k++) begin
         w = 8'($urandom);
         sent.push_back(w);
         push(w);
      end
      wait_idle(4000);
      repeat (8) @(negedge CLK);
      check("lb_words", rx.size() - rb, 50);
      check("lb_pulses", rx_pulses - rp, 50);
      if (rx.size() - rb == 50)
         for (int k = 0; k < 50; k++) check("lb_word", rx[rb+k], sent[k]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/data_sync_tx.md
Name: data_sync_tx

Overview:
Source-domain transmitter for the multi-flop enable-synchronized bus crossing. Accepts words on a valid/ready interface in the CLK domain, drives a held data bus plus a level enable (bus_EN) toward the destination-domain synchronizer, and runs a 4-phase handshake using an asynchronous acknowledge returned from the destination domain. A one-entry pending buffer lets the next word be accepted while the current transfer is in flight.

Parameters:
NUM_Stages, 2, number of synchronizer flops on bus_ACK (>=2)
Width, 8, data bus width

Ports:
CLK  input  1  source-domain clock
Reset  input  1  asynchronous active-low reset
in_data  input  Width  word to transmit
in_valid  input  1  in_data valid
in_ready  output  1  block can accept in_data this cycle
Async_bus  output  Width  registered data held toward destination domain
bus_EN  output  1  registered request level toward destination synchronizer
bus_ACK  input  1  asynchronous acknowledge level from destination domain (echo of synchronized bus_EN)
busy  output  1  transfer in progress (state != IDLE)
done_pulse  output  1  one-cycle pulse when a transfer's handshake completes

Behaviour:
- Reset: Reset, asynchronous, active-low; clock CLK. On reset: Async_bus=0, bus_EN=0, busy=0, done_pulse=0, pending buffer empty, all ack sync flops=0, state=IDLE; in_ready=1 once reset releases.
- Ack sync: bus_ACK passes through NUM_Stages flops; ack_s = last stage. FSM uses only ack_s, never raw bus_ACK.
- Pending buffer: one data register plus a full flag. Accept when in_valid & in_ready; the word is written to pending at that edge.
- in_ready = ~pend_full | (state==IDLE). In IDLE, a full pending buffer drains at this edge, so the buffer can accept and drain in the same cycle.
- FSM states: IDLE, LOAD, REQ, DROP.
- IDLE: bus_EN=0. If pend_full: Async_bus<=pending data, pend_full cleared (unless refilled at the same edge), go to LOAD. Otherwise stay.
- LOAD: one cycle for data setup; Async_bus stable; bus_EN<=1; go to REQ.
- REQ: bus_EN=1. Wait for ack_s==1, then bus_EN<=0 and go to DROP.
- DROP: bus_EN=0. Wait for ack_s==0, then go to IDLE with done_pulse=1 for exactly that one cycle.
- Async_bus changes only on the IDLE->LOAD edge. It is stable from LOAD until the next load, which meets the destination's capture-on-synchronized-edge requirement.
- bus_EN is driven directly from a flop with no combinational path, so the destination sees a glitch-free level.
- Latency:
  - in_valid accepted at edge 0 (IDLE, pending empty) -> Async_bus valid after edge 1 -> bus_EN high after edge 2.
  - Handshake length = 2 + 2*(NUM_Stages + destination round-trip) cycles minimum.
- No timeout: a stuck bus_ACK holds the FSM in REQ or DROP indefinitely. in_ready stays low once pending is full.
- ack_s already 1 on entering REQ (illegal, stale ack): treated as ack; transition to DROP next edge. Ack falling while in REQ before rising: ignored.
- Reset mid-transfer: immediate return to reset values. bus_EN drops asynchronously; the pending word is lost.
- in_data is ignored when not accepted; in_valid may drop without acceptance.

Test Plan:
- Single word: model bus_ACK = bus_EN delayed 3 CLK. Accept 0xA5 at edge 0 -> Async_bus=0xA5 after edge 1, bus_EN=1 after edge 2, bus_EN falls 1 cycle after ack_s rises, done_pulse single cycle, busy low afterwards.
- Back-to-back: hold in_valid high with 0x11, 0x22, 0x33. Required: 0x22 accepted while 0x11 is in flight; in_ready=0 when pending is full and state!=IDLE; in_ready=1 in the IDLE drain cycle; Async_bus sequence 0x11, 0x22, 0x33 each held through its full handshake; exactly 3 done_pulses.
- Stuck ack: bus_ACK held 0. Required: bus_EN stays 1, busy=1, one more word accepted, then in_ready=0. Releasing the ack completes both transfers in order.
- Data stability: toggle in_data randomly while not accepted. Required: Async_bus never changes except on IDLE->LOAD edges; bus_EN never rises in the same cycle Async_bus changes.
- Reset mid-REQ: assert Reset while bus_EN=1. Required: bus_EN, Async_bus, busy go 0 immediately; after release in_ready=1 and the next word transfers normally.
- Destination loopback: connect to the destination synchronizer on an unrelated clock (ratio 3:7), bus_ACK taken from its synchronized enable. Send 50 random words. Required: the destination sync_bus sequence matches the sent words exactly, with one EN_pulse per word.
